// File: rtl/led_pattern_recorder.sv
// Button-driven writer for the shared LED pattern memory: btn1 steps the edit value, btn2 commits it.
// Optional: define LED_PATTERN_RECORDER_AUTO_REPEAT_EN for btn1 auto-repeat while held.
module led_pattern_recorder #(
    parameter int DEPTH           = 5,
    parameter int DATA_W          = 6,
    parameter int ADDR_W          = 3,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int REPEAT_CYCLES   = 6750000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn1,
    input  logic              btn2,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] entry,
    output logic [ADDR_W-1:0] count,
    output logic              full
);
    localparam int NBTN = 2;
    localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]     CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {EDIT, FULL} state_t;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] press;
    logic            inc;
    state_t          state, state_n;

    assign btn_raw = {btn2, btn1};

    // Per-button sync + debounce; press fires on the edge the debounced level falls.
    generate
        for (genvar i = 0; i < NBTN; i++) begin : g_btn
            logic          s1, s2, lvl, p;
            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1  <= 1'b1;
                    s2  <= 1'b1;
                    lvl <= 1'b1;
                    cnt <= '0;
                    p   <= 1'b0;
                end else begin
                    s1 <= btn_raw[i];
                    s2 <= s1;
                    p  <= 1'b0;
                    if (s2 == lvl) begin
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        lvl <= s2;
                        cnt <= '0;
                        p   <= ~s2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign press[i] = p;
        end
    endgenerate

`ifdef LED_PATTERN_RECORDER_AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rcnt;
    logic          rep;

    // A btn2 pulse clears the counter first, so a repeat never lands on a commit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt <= '0;
            rep  <= 1'b0;
        end else begin
            rep <= 1'b0;
            if (g_btn[0].lvl || state != EDIT || press[1]) begin
                rcnt <= '0;
            end else if (rcnt == REP_MAX) begin
                rcnt <= '0;
                rep  <= 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    assign inc = press[0] | rep;
`else
    assign inc = press[0];
`endif

    logic              wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n, ptr, ptr_n, count_n;
    logic [DATA_W-1:0] wr_data_n, entry_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EDIT;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            entry   <= '0;
            count   <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            entry   <= entry_n;
            count   <= count_n;
            ptr     <= ptr_n;
        end
    end

    // btn2 takes priority; a coincident increment is dropped.
    always_comb begin
        state_n   = state;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        entry_n   = entry;
        count_n   = count;
        ptr_n     = ptr;
        case (state)
            EDIT: begin
                if (press[1]) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = ptr;
                    wr_data_n = entry;
                    entry_n   = '0;
                    count_n   = count + 1'b1;
                    if (ptr == LAST) begin
                        ptr_n   = '0;
                        state_n = FULL;
                    end else begin
                        ptr_n = ptr + 1'b1;
                    end
                end else if (inc) begin
                    entry_n = entry + 1'b1;
                end
            end
            FULL: begin
                entry_n = '0;
                if (press[1]) begin
                    ptr_n   = '0;
                    count_n = '0;
                    state_n = EDIT;
                end
            end
            default: state_n = EDIT;
        endcase
    end

    assign full = (state == FULL);

endmodule
